// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and size helpers for the parametrised synchronous FIFO.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default geometry (16-bit words, 4 entries)
//   depth_of(aw)                    : number of entries for a given pointer width
//   count_width(aw)                 : bits needed to hold an occupancy of 0..depth_of(aw)
package sync_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 2;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // One extra bit so that a completely full FIFO (count == depth) is representable.
    function automatic int unsigned count_width(input int unsigned aw);
        return aw + 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: simple dual-port register array with one write port and one registered
// read port. Storage is not reset; only the read data register is cleared by rst.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears rdata only)
//   we    : write enable, wdata stored at waddr
//   waddr : write address
//   wdata : write data
//   re    : read enable, rdata loaded from raddr; rdata holds otherwise
//   raddr : read address
//   rdata : registered read data
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and optional sticky error flags.
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN (builds sticky overflow/underflow logic;
// when undefined both flags are tied low).
//   clk           : clock, rising edge
//   rstp          : synchronous active-high reset
//   din / writep  : write data and write request (ignored while full or in reset)
//   readp         : read request (ignored while empty or in reset)
//   dout          : registered read data, valid the cycle after an accepted read
//   emptyp/fullp  : occupancy is 0 / DEPTH
//   almost_emptyp : count <= AE_THRESH
//   almost_fullp  : count >= AF_THRESH
//   count         : occupancy 0..DEPTH
//   overflowp     : sticky, write requested while full
//   underflowp    : sticky, read requested while empty
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned AF_THRESH  = 3,
    parameter int unsigned AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rstp,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  writep,
    input  logic                  readp,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  emptyp,
    output logic                  fullp,
    output logic                  almost_emptyp,
    output logic                  almost_fullp,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflowp,
    output logic                  underflowp
);

    localparam int unsigned COUNT_W = count_width(ADDR_WIDTH);
    localparam int unsigned DEPTH   = depth_of(ADDR_WIDTH);

    localparam logic [COUNT_W-1:0] DepthLvl = COUNT_W'(DEPTH);
    localparam logic [COUNT_W-1:0] AfLvl    = COUNT_W'(AF_THRESH);
    localparam logic [COUNT_W-1:0] AeLvl    = COUNT_W'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] head_q, tail_q;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  empty_q, full_q, aempty_q, afull_q;
    logic                  wr_en, rd_en;

    // Acceptance uses the registered flags; both are masked during reset so memory
    // and dout are left untouched by requests in a reset cycle.
    assign wr_en = writep & ~full_q  & ~rstp;
    assign rd_en = readp  & ~empty_q & ~rstp;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + COUNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - COUNT_W'(1);
        end
    end

    // Flags are derived from the next count so they move on the same edge as count.
    always_ff @(posedge clk) begin
        if (rstp) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            aempty_q <= 1'b1;
            afull_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                head_q <= head_q + 1'b1;
            end
            if (rd_en) begin
                tail_q <= tail_q + 1'b1;
            end
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == DepthLvl);
            aempty_q <= (count_d <= AeLvl);
            afull_q  <= (count_d >= AfLvl);
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rstp),
        .we    (wr_en),
        .waddr (head_q),
        .wdata (din),
        .re    (rd_en),
        .raddr (tail_q),
        .rdata (dout)
    );

    assign count         = count_q;
    assign emptyp        = empty_q;
    assign fullp         = full_q;
    assign almost_emptyp = aempty_q;
    assign almost_fullp  = afull_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky: judged on the raw requests against the current flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rstp) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (writep && full_q) begin
                overflow_q <= 1'b1;
            end
            if (readp && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflowp  = overflow_q;
    assign underflowp = underflow_q;
`else
    assign overflowp  = 1'b0;
    assign underflowp = 1'b0;
`endif

endmodule
